multicycle_controller: RTL and testbench

Multicycle control unit for the RISC-V datapath. It decodes the fetched instruction's opcode and function fields and steps a Moore state machine through fetch, decode, execute, memory and write-back. It drives the datapath multiplexer selects, the write enables and the 3-bit `alucontrol` of the ALU, and it consumes the ALU zero flag `Z` to resolve `beq`. It sits directly upstream of the ALU and stalls on a single-bit memory-ready handshake.

---
 rtl/riscv_pkg.sv | 131 +++++++++++++
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 90 +++++++++
 tb/tb_multicycle_controller.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_pkg : shared state, opcode, ALU and select encodings                |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } statetype_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // fetch/branch/jump are qualifiers later combined with mem_ready/zero
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        aluop_t     aluop;
        logic       fetch;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(statetype_t s);
        ctrl_t c;
        c       = '0;
        c.aluop = ALUOP_ADD;
        case (s)
            S_FETCH: begin
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
                c.fetch      = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.aluop     = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.aluop     = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.jump      = 1'b1;
            end
            S_ILLEGAL: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_controller_if : controller <-> datapath signal bundle          |
// | Revision                 : 1.0                                            |
// +--------------------------------------------------------------------------+
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alucontrol;
    logic       illegal_op;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alucontrol, illegal_op
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alucontrol, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_decoder : ALUOp/funct3 to alucontrol, flags unsupported funct3        |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module alu_decoder
    import riscv_pkg::*;
(
    input  aluop_t     aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alucontrol_o,
    output logic       funct_illegal_o
);

    always_comb begin
        alucontrol_o    = ALU_ADD;
        funct_illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7b5 only means sub for register-register ops
                    3'b000:  alucontrol_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol_o = ALU_SLT;
                    3'b110:  alucontrol_o = ALU_OR;
                    3'b111:  alucontrol_o = ALU_AND;
                    default: funct_illegal_o = 1'b1;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_controller : Moore FSM sequencing the multicycle RISC-V path   |
// | Revision              : 1.0                                               |
// +--------------------------------------------------------------------------+
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);

    statetype_t state_q, state_d;
    ctrl_t      ctrl_q;
    logic [2:0] alucontrol;
    logic       funct_illegal;

    alu_decoder u_alu_dec (
        .aluop_i        (ctrl_q.aluop),
        .funct3_i       (bus.funct3),
        .op5_i          (bus.op[5]),
        .funct7b5_i     (bus.funct7b5),
        .alucontrol_o   (alucontrol),
        .funct_illegal_o(funct_illegal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_IALU:      state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECUTER,
            S_EXECUTEI: state_d = funct_illegal ? S_ILLEGAL : S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output flags are registered alongside the state so they track state_q exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    // Enables are gated by rst_n so a held reset cannot leak a fetch strobe
    assign bus.pc_write   = rst_n & ((ctrl_q.fetch & bus.mem_ready) | ctrl_q.jump |
                                     (ctrl_q.branch & bus.zero));
    assign bus.ir_write   = rst_n & ctrl_q.fetch & bus.mem_ready;
    assign bus.mem_write  = rst_n & ctrl_q.mem_write;
    assign bus.reg_write  = rst_n & ctrl_q.reg_write;
    assign bus.illegal_op = rst_n & ctrl_q.illegal;
    assign bus.adr_src    = ctrl_q.adr_src;
    assign bus.result_src = ctrl_q.result_src;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.alucontrol = alucontrol;

    always_comb begin
        case (bus.op)
            OP_SW:   bus.imm_src = IMM_S;
            OP_BEQ:  bus.imm_src = IMM_B;
            OP_JAL:  bus.imm_src = IMM_J;
            default: bus.imm_src = IMM_I;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_controller : directed + random checks against a phase model |
// | Revision                 : 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if u_if ();

    multicycle_controller dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if)
    );

    int checks = 0;
    int errors = 0;
    int ir_cnt = 0;

    typedef enum {P_F, P_D, P_MA, P_MR, P_MW, P_MWB, P_ER, P_EI, P_AWB, P_BEQ, P_JAL, P_ILL} phase_e;
    typedef struct {
        phase_e ph;
        bit     rdy;
        bit     z;
    } step_t;

    localparam logic [6:0] C_LW  = 7'b0000011;
    localparam logic [6:0] C_SW  = 7'b0100011;
    localparam logic [6:0] C_R   = 7'b0110011;
    localparam logic [6:0] C_I   = 7'b0010011;
    localparam logic [6:0] C_BEQ = 7'b1100011;
    localparam logic [6:0] C_JAL = 7'b1101111;

    function automatic bit rb();
        return bit'($urandom & 1);
    endfunction

    function automatic bit legal_f3(logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    // Expected vector: {pc_write, adr_src, mem_write, ir_write, reg_write,
    //                   result_src, alu_src_a, alu_src_b, imm_src, alucontrol, illegal_op}
    function automatic logic [16:0] model(phase_e ph, bit rdy, bit z, bit rstl,
                                          logic [6:0] o, logic [2:0] f3, logic f7);
        bit pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0, fn = 0;
        logic [1:0] rs = 2'd0, sa = 2'd0, sb = 2'd0, imm;
        logic [2:0] alu = 3'd0;
        imm = (o == C_SW) ? 2'd1 : (o == C_BEQ) ? 2'd2 : (o == C_JAL) ? 2'd3 : 2'd0;
        case (ph)
            P_F:   begin sb = 2'd2; rs = 2'd2; irw = rdy; pcw = rdy; end
            P_D:   begin sa = 2'd1; sb = 2'd1; end
            P_MA:  begin sa = 2'd2; sb = 2'd1; end
            P_MR:  adr = 1;
            P_MW:  begin adr = 1; mw = 1; end
            P_MWB: begin rs = 2'd1; rw = 1; end
            P_ER:  begin sa = 2'd2; fn = 1; end
            P_EI:  begin sa = 2'd2; sb = 2'd1; fn = 1; end
            P_AWB: rw = 1;
            P_BEQ: begin sa = 2'd2; alu = 3'd1; pcw = z; end
            P_JAL: begin sa = 2'd1; sb = 2'd2; pcw = 1; end
            P_ILL: ill = 1;
            default: ;
        endcase
        if (fn) begin
            case (f3)
                3'd0:    alu = (o[5] && f7) ? 3'd1 : 3'd0;
                3'd2:    alu = 3'd5;
                3'd6:    alu = 3'd3;
                3'd7:    alu = 3'd2;
                default: alu = 3'd0;
            endcase
        end
        if (!rstl) begin
            pcw = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        end
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {u_if.pc_write, u_if.adr_src, u_if.mem_write, u_if.ir_write, u_if.reg_write,
                u_if.result_src, u_if.alu_src_a, u_if.alu_src_b, u_if.imm_src,
                u_if.alucontrol, u_if.illegal_op};
    endfunction

    task automatic check_vec(input string tag, input logic [16:0] exp);
        logic [16:0] got;
        got = observed();
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Entered at posedge+1; inputs apply to the current cycle, outputs checked at negedge
    task automatic step(input phase_e ph, input bit rdy, input bit z, input string tag);
        u_if.mem_ready = rdy;
        u_if.zero      = z;
        @(negedge clk);
        check_vec(tag, model(ph, rdy, z, 1'b1, u_if.op, u_if.funct3, u_if.funct7b5));
        ir_cnt += int'(u_if.ir_write);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input string tag);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            u_if.mem_ready = 1'b1;
            u_if.zero      = 1'b1;
            @(negedge clk);
            check_vec($sformatf("%s rst%0d", tag, i),
                      model(P_F, 1'b1, 1'b1, 1'b0, u_if.op, u_if.funct3, u_if.funct7b5));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int fw, input int mwait, input bit zb, input string name);
        step_t q[$];
        u_if.op       = o;
        u_if.funct3   = f3;
        u_if.funct7b5 = f7;
        for (int i = 0; i < fw; i++) q.push_back('{ph: P_F, rdy: 1'b0, z: rb()});
        q.push_back('{ph: P_F, rdy: 1'b1, z: rb()});
        q.push_back('{ph: P_D, rdy: rb(), z: rb()});
        case (o)
            C_LW: begin
                q.push_back('{ph: P_MA, rdy: rb(), z: rb()});
                for (int i = 0; i < mwait; i++) q.push_back('{ph: P_MR, rdy: 1'b0, z: rb()});
                q.push_back('{ph: P_MR, rdy: 1'b1, z: rb()});
                q.push_back('{ph: P_MWB, rdy: rb(), z: rb()});
            end
            C_SW: begin
                q.push_back('{ph: P_MA, rdy: rb(), z: rb()});
                for (int i = 0; i < mwait; i++) q.push_back('{ph: P_MW, rdy: 1'b0, z: rb()});
                q.push_back('{ph: P_MW, rdy: 1'b1, z: rb()});
            end
            C_R, C_I: begin
                q.push_back('{ph: (o == C_R) ? P_ER : P_EI, rdy: rb(), z: rb()});
                q.push_back('{ph: legal_f3(f3) ? P_AWB : P_ILL, rdy: rb(), z: rb()});
            end
            C_BEQ: q.push_back('{ph: P_BEQ, rdy: rb(), z: zb});
            C_JAL: begin
                q.push_back('{ph: P_JAL, rdy: rb(), z: rb()});
                q.push_back('{ph: P_AWB, rdy: rb(), z: rb()});
            end
            default: q.push_back('{ph: P_ILL, rdy: rb(), z: rb()});
        endcase
        foreach (q[i]) step(q[i].ph, q[i].rdy, q[i].z, $sformatf("%s c%0d", name, i));
    endtask

    task automatic hold_illegal(input int n, input string name);
        for (int i = 0; i < n; i++) step(P_ILL, rb(), rb(), $sformatf("%s ill%0d", name, i));
        do_reset(2, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [6];
        ops = '{C_LW, C_SW, C_R, C_I, C_BEQ, C_JAL};
        rst_n          = 1'b1;
        u_if.op        = C_R;
        u_if.funct3    = 3'd0;
        u_if.funct7b5  = 1'b0;
        u_if.zero      = 1'b0;
        u_if.mem_ready = 1'b0;
        #2;
        @(posedge clk);
        #1;
        do_reset(3, "init");

        run_instr(C_R, 3'b000, 1'b0, 0, 0, 1'b0, "add");
        run_instr(C_R, 3'b000, 1'b1, 0, 0, 1'b0, "sub");
        run_instr(C_R, 3'b010, 1'b0, 0, 0, 1'b0, "slt");
        run_instr(C_I, 3'b000, 1'b1, 0, 0, 1'b0, "addi_f7");
        run_instr(C_I, 3'b110, 1'b0, 1, 0, 1'b0, "ori");
        run_instr(C_R, 3'b111, 1'b0, 0, 0, 1'b0, "and");

        ir_cnt = 0;
        run_instr(C_LW, 3'b010, 1'b0, 2, 3, 1'b0, "lw_wait");
        check_int("lw_ir_pulses", ir_cnt, 1);

        run_instr(C_SW, 3'b010, 1'b0, 0, 2, 1'b0, "sw_wait");
        run_instr(C_BEQ, 3'b000, 1'b0, 0, 0, 1'b1, "beq_taken");
        run_instr(C_BEQ, 3'b000, 1'b0, 0, 0, 1'b0, "beq_not");
        run_instr(C_JAL, 3'b000, 1'b0, 1, 0, 1'b0, "jal");

        // abandon a store mid-wait
        u_if.op     = C_SW;
        u_if.funct3 = 3'b010;
        step(P_F, 1'b1, 1'b0, "swab f");
        step(P_D, 1'b0, 1'b0, "swab d");
        step(P_MA, 1'b1, 1'b0, "swab ma");
        step(P_MW, 1'b0, 1'b0, "swab mw");
        do_reset(3, "swab");
        run_instr(C_R, 3'b000, 1'b0, 0, 0, 1'b0, "post_rst");

        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, "badop");
        hold_illegal(20, "badop");
        run_instr(C_R, 3'b001, 1'b0, 0, 0, 1'b0, "rf3_001");
        hold_illegal(5, "rf3_001");

        for (int n = 0; n < 40; n++) begin
            int         cls;
            logic [6:0] o;
            logic [2:0] f3;
            cls = int'($urandom_range(0, 6));
            if (cls == 6) begin
                o = 7'($urandom);
                if (o == C_LW || o == C_SW || o == C_R || o == C_I || o == C_BEQ || o == C_JAL)
                    o = 7'b1111111;
            end else begin
                o = ops[cls];
            end
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom);
            if (($urandom & 1) == 1) begin
                case ($urandom_range(0, 3))
                    0: f3 = 3'd0;
                    1: f3 = 3'd2;
                    2: f3 = 3'd6;
                    default: f3 = 3'd7;
                endcase
            end
            run_instr(o, f3, rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      rb(), $sformatf("rnd%0d", n));
            if (cls == 6 || ((cls == 2 || cls == 3) && !legal_f3(f3)))
                hold_illegal(3, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
